rv_alu_mc: RTL and testbench

- Parametrised, sequential successor to the combinational RV32I ALU.
- Adds the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), implemented with an iterative shift-add multiplier and a restoring divider.
- Uses valid/ready handshakes on both input and output, so the execute stage can stall on multi-cycle operations.
- Sits between operand-select and writeback in the execute stage.

---
 rtl/rv_alu_mc.sv | 178 +++++++++++++++++
 tb/tb_rv_alu_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_mc.sv
// rv_alu_mc: RV32I ALU plus iterative RV32M multiply/divide behind valid/ready handshakes.
// Multiply is shift-add on magnitudes, divide is restoring; both spend WIDTH cycles in CALC.
module rv_alu_mc #(
    parameter int WIDTH    = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rez,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0]   CNT_LAST = '1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic               hi_q, hi_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   rez_q, rez_d;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic               is_op, is_imm, m_enc, is_m, base_op, add_op;
    logic               f_mul, f_rem, s1, s2, div_zero, div_ovf, div_spec;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res, spec_res, mag1, mag2;

    always_comb begin
        is_op    = (opcode == 7'b0110011);
        is_imm   = (opcode == 7'b0010011);
        m_enc    = is_op && (funct7 == 7'b0000001);
        is_m     = ENABLE_M && m_enc;
        base_op  = is_imm || (is_op && !m_enc);
        add_op   = (opcode == 7'b0000011) || (opcode == 7'b0100011) || (opcode == 7'b1100111) ||
                   (opcode == 7'b1101111) || (opcode == 7'b0010111) || (opcode == 7'b1100011);
        shamt    = op2[SHW-1:0];
        alu_res  = op1;
        if (base_op) begin
            case (funct3)
                3'b000:  alu_res = (is_op && funct7[5]) ? op1 - op2 : op1 + op2;
                3'b001:  alu_res = op1 << shamt;
                3'b010:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
                3'b011:  alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
                3'b100:  alu_res = op1 ^ op2;
                3'b101:  alu_res = funct7[5] ? WIDTH'($signed(op1) >>> shamt) : op1 >> shamt;
                3'b110:  alu_res = op1 | op2;
                default: alu_res = op1 & op2;
            endcase
        end else if (add_op) begin
            alu_res = op1 + op2;
        end

        // Signedness per M op: MULH both, MULHSU op1 only, DIV/REM both, unsigned forms none.
        f_mul    = !funct3[2];
        f_rem    = funct3[1];
        s1       = op1[WIDTH-1] && (f_mul ? (funct3 == 3'b001 || funct3 == 3'b010) : !funct3[0]);
        s2       = op2[WIDTH-1] && (f_mul ? (funct3 == 3'b001) : !funct3[0]);
        mag1     = cond_neg(op1, s1);
        mag2     = cond_neg(op2, s2);
        div_zero = (op2 == '0);
        div_ovf  = !funct3[0] && (op1 == MOST_NEG) && (op2 == '1);
        div_spec = !f_mul && (div_zero || div_ovf);
        spec_res = div_zero ? (f_rem ? op1 : '1) : (f_rem ? '0 : op1);
    end

    logic [2*WIDTH-1:0] mul_sum, mul_fin, div_nxt;
    logic [WIDTH:0]     rem_sh, rem_dif;
    logic [WIDTH-1:0]   div_val, fin_res;

    // acc holds the product for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum = acc_q + (opb_q[0] ? opa_q : '0);
        mul_fin = neg_q ? -mul_sum : mul_sum;
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_dif = rem_sh - {1'b0, opa_q[WIDTH-1:0]};
        div_nxt = rem_dif[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {rem_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        div_val = hi_q ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
        fin_res = div_q ? cond_neg(div_val, neg_q)
                        : (hi_q ? mul_fin[2*WIDTH-1:WIDTH] : mul_fin[WIDTH-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        div_d     = div_q;
        rez_d     = rez_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_m && !div_spec) begin
                        state_d = CALC;
                        cnt_d   = '0;
                        div_d   = !f_mul;
                        neg_d   = (!f_mul && f_rem) ? s1 : (s1 ^ s2);
                        hi_d    = f_mul ? (funct3 != 3'b000) : f_rem;
                        acc_d   = f_mul ? '0 : {{WIDTH{1'b0}}, mag1};
                        opa_d   = {{WIDTH{1'b0}}, (f_mul ? mag1 : mag2)};
                        opb_d   = mag2;
                    end else begin
                        state_d = DONE;
                        rez_d   = is_m ? spec_res : alu_res;
                    end
                end
            end
            CALC: begin
                busy  = 1'b1;
                cnt_d = cnt_q + SHW'(1);
                acc_d = div_q ? div_nxt : mul_sum;
                opa_d = div_q ? opa_q : {opa_q[2*WIDTH-2:0], 1'b0};
                opb_d = opb_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    rez_d   = fin_res;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            div_q   <= 1'b0;
            rez_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            div_q   <= div_d;
            rez_q   <= rez_d;
        end
    end

    assign rez = rez_q;

endmodule

// File: tb/tb_rv_alu_mc.sv
// Scoreboard bench for rv_alu_mc: directed vectors push expected result/latency/busy-count,
// a negedge monitor pops on each output handshake; a second ENABLE_M=0 instance is checked directly.
module tb_rv_alu_mc;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] F7M = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_valid2 = 1'b0;
    logic        in_ready, in_ready2;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        out_valid, out_valid2;
    logic        out_ready = 1'b1;
    logic [31:0] rez, rez2;
    logic        busy, busy2;

    rv_alu_mc #(.WIDTH(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready), .rez(rez), .busy(busy));

    rv_alu_mc #(.WIDTH(32), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .op1(op1), .op2(op2),
        .out_valid(out_valid2), .out_ready(1'b1), .rez(rez2), .busy(busy2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rez;
        int          lat;
        int          bsy;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency from the first cycle out_valid is seen, busy cycles since last result.
    int          ov_first = -1;
    int          busy_cnt = 0;
    logic [31:0] ov_rez;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_first = -1;
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (ov_first < 0) begin
                    ov_first = cyc;
                    ov_rez   = rez;
                end else begin
                    chk("hold_rez", rez, ov_rez);
                end
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got %h expected none", rez);
                    end else begin
                        e = sbq.pop_front();
                        chk("rez", rez, e.rez);
                        chk("latency", 32'(ov_first - e.acc + 1), 32'(e.lat));
                        chk("busy_cycles", 32'(busy_cnt), 32'(e.bsy));
                    end
                    ov_first = -1;
                    busy_cnt = 0;
                end
            end
        end
    end

    // Called and returns at posedge+#1; accepted on the first edge where in_ready is high.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input int lat, input int bsy, input bit push);
        exp_t e;
        int   n;
        opcode = opc; funct3 = f3; funct7 = f7; op1 = a; op2 = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready %b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = 32'hDEADBEEF; op2 = 32'h0BADF00D; opcode = 7'b1111111;
        if (push) begin
            e.rez = exp; e.lat = lat; e.bsy = bsy; e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rez", rez, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        issue(OP,  3'b000, 7'b0100000, 32'd5,        32'd7,        32'hFFFFFFFE, 1, 0, 1);
        issue(IMM, 3'b101, 7'b0100000, 32'h80000000, 32'd4,        32'hF8000000, 1, 0, 1);
        issue(OP,  3'b101, 7'b0000000, 32'h80000000, 32'd4,        32'h08000000, 1, 0, 1);
        issue(OP,  3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd1,        1, 0, 1);
        issue(OP,  3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 1);
        issue(IMM, 3'b001, 7'b0000000, 32'd1,        32'h23,       32'd8,        1, 0, 1);
        issue(OP,  3'b111, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 0, 1);
        issue(IMM, 3'b000, 7'b0100000, 32'd5,        32'd7,        32'd12,       1, 0, 1);
        issue(7'b0000011, 3'b010, 7'b0, 32'h1000,    32'h24,       32'h1024,     1, 0, 1);
        issue(7'b0110111, 3'b000, 7'b0, 32'hABCDE000, 32'd5,       32'hABCDE000, 1, 0, 1);

        // Multiply
        issue(OP, 3'b000, F7M, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 33, 32, 1);
        issue(OP, 3'b001, F7M, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 33, 32, 1);
        issue(OP, 3'b011, F7M, 32'hFFFFFFFF, 32'd3, 32'h00000002, 33, 32, 1);
        issue(OP, 3'b010, F7M, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 33, 32, 1);
        issue(OP, 3'b011, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, 1);

        // Divide
        issue(OP, 3'b100, F7M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 32, 1);
        issue(OP, 3'b110, F7M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 32, 1);
        issue(OP, 3'b101, F7M, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, 32, 1);
        issue(OP, 3'b111, F7M, 32'hFFFFFFF9, 32'd2, 32'h00000001, 33, 32, 1);
        issue(OP, 3'b100, F7M, 32'd100,      32'd7, 32'd14,       33, 32, 1);
        issue(OP, 3'b110, F7M, 32'd100,      32'd7, 32'd2,        33, 32, 1);

        // Divide special cases and their unsigned non-special neighbours
        issue(OP, 3'b100, F7M, 32'd9,        32'd0,        32'hFFFFFFFF, 1, 0, 1);
        issue(OP, 3'b110, F7M, 32'd9,        32'd0,        32'd9,        1, 0, 1);
        issue(OP, 3'b101, F7M, 32'd9,        32'd0,        32'hFFFFFFFF, 1, 0, 1);
        issue(OP, 3'b100, F7M, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1);
        issue(OP, 3'b110, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, 1);
        issue(OP, 3'b101, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 32, 1);
        issue(OP, 3'b111, F7M, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 32, 1);
        drain();

        // Backpressure: MUL result held while a new op waits
        out_ready = 1'b0;
        issue(OP, 3'b000, F7M, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 33, 32, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        opcode = OP; funct3 = 3'b000; funct7 = 7'b0; op1 = 32'h10; op2 = 32'h20;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_rez", rez, 32'hFFFFFFFD);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        issue(OP, 3'b000, 7'b0, 32'h10, 32'h20, 32'h30, 1, 0, 1);
        drain();

        // Reset in the middle of a DIVU: no result may ever appear for it
        issue(OP, 3'b101, F7M, 32'd1000, 32'd3, 32'd0, 33, 32, 0);
        repeat (9) @(posedge clk);
        #2;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_rez", rez, 32'd0);
        chk("areset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("areset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_reset_idle", {31'd0, out_valid}, 32'd0);

        // ENABLE_M=0: MUL encoding passes op1 through in one cycle
        opcode = OP; funct3 = 3'b000; funct7 = F7M; op1 = 32'd6; op2 = 32'd7;
        in_valid2 = 1'b1;
        chk("nom_in_ready", {31'd0, in_ready2}, 32'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("nom_out_valid", {31'd0, out_valid2}, 32'd1);
        chk("nom_rez", rez2, 32'd6);
        chk("nom_busy", {31'd0, busy2}, 32'd0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
